// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the count_sequencer block: FSM state encoding,
// step width and the saturating count update.
package count_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam int STEP_W = 4;
  // Widest count/limit the helper supports; callers zero-extend into it.
  localparam int MAX_W  = 16;

  // cur + step clamped to lim, computed one bit wider so it can never wrap.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0]  cur,
                                               input logic [STEP_W-1:0] step,
                                               input logic [MAX_W-1:0]  lim);
    logic [MAX_W:0] sum;
    sum = {1'b0, cur} + {{(MAX_W + 1 - STEP_W){1'b0}}, step};
    if (sum > {1'b0, lim}) return lim;
    return sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler for count_sequencer: pulses tick on every DIV-th enabled clock,
// holds its value while disabled, and restarts from zero on clr.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // DIV is limited to 1..255, so 8 bits always hold the prescaler.
  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] pre;

  assign tick = en && (pre == LAST);

  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 8'd1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven counter sequencer: accepts (limit, step), advances the count on
// prescaler ticks up to limit, with pause, abort and one-cycle done/aborted pulses.
module count_sequencer #(
  parameter int DIV = 1,
  parameter int W   = 8
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_limit,
  input  logic [3:0]   cmd_step,
  input  logic         pause,
  input  logic         abort,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  import count_seq_pkg::*;

  state_t              state, state_nxt;
  logic [W-1:0]        limit_q;
  logic [W-1:0]        count_q;
  logic [W-1:0]        count_adv;
  logic [STEP_W-1:0]   step_q;
  logic                accept;
  logic                active;
  logic                tick_en;
  logic                tick;
  logic                aborted_q;

  assign accept = (state == IDLE) && cmd_valid;
  assign active = (state == RUN) || (state == PAUSE);
  // The prescaler also runs on the edge that leaves PAUSE, so a pause of N
  // cycles delays completion by exactly N cycles; abort and pause block it.
  assign tick_en = active && !pause && !abort;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (accept),
    .en     (tick_en),
    .tick   (tick)
  );

  assign count_adv = W'(sat_add(MAX_W'(count_q), step_q, MAX_W'(limit_q)));

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (cmd_valid) state_nxt = (cmd_limit == '0) ? DONE : RUN;
      RUN, PAUSE: begin
        if (abort)                              state_nxt = IDLE;
        else if (pause)                         state_nxt = PAUSE;
        else if (tick && (count_adv == limit_q)) state_nxt = DONE;
        else                                    state_nxt = RUN;
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      count_q   <= '0;
      limit_q   <= '0;
      step_q    <= STEP_W'(1);
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= active && abort;
      if (accept) begin
        limit_q <= cmd_limit;
        step_q  <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
        count_q <= '0;
      end else if (tick) begin
        count_q <= count_adv;
      end
    end
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = active;
    done      = (state == DONE);
  end

  assign count   = count_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: table-driven runs scored against a
// queue of expected count updates, plus abort and reset-mid-run sequences.
module tb_count_sequencer;

  typedef struct {
    bit         div2;
    logic [7:0] limit;
    logic [3:0] step;
    int         pause_at;
    int         plen;
    logic [7:0] final_cnt;
    int         done_cyc;
  } vec_t;

  typedef struct {
    int         at;
    logic [7:0] val;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst, cmd_valid, pause, abort;
  logic [7:0] cmd_limit;
  logic [3:0] cmd_step;

  logic       rdy1, busy1, done1, ab1;
  logic [7:0] cnt1;
  logic       rdy2, busy2, done2, ab2;
  logic [7:0] cnt2;

  bit         sel;
  logic [7:0] count;
  logic       cmd_ready, busy, done, aborted;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk_in = ~clk_in;

  count_sequencer #(.DIV(1), .W(8)) u_div1 (
    .clk_in(clk_in), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_limit(cmd_limit), .cmd_step(cmd_step), .pause(pause), .abort(abort),
    .count(cnt1), .busy(busy1), .done(done1), .aborted(ab1)
  );

  count_sequencer #(.DIV(2), .W(8)) u_div2 (
    .clk_in(clk_in), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
    .cmd_limit(cmd_limit), .cmd_step(cmd_step), .pause(pause), .abort(abort),
    .count(cnt2), .busy(busy2), .done(done2), .aborted(ab2)
  );

  always_comb begin
    count     = sel ? cnt2  : cnt1;
    cmd_ready = sel ? rdy2  : rdy1;
    busy      = sel ? busy2 : busy1;
    done      = sel ? done2 : done1;
    aborted   = sel ? ab2   : ab1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1; cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  // Issue one command, then check every cycle until two cycles past done.
  task automatic run_vec(input vec_t v);
    int         d, st, acc, k;
    logic [7:0] exp_cnt;
    exp_t       e;
    sel = v.div2;
    d   = v.div2 ? 2 : 1;
    st  = (v.step == 4'd0) ? 1 : int'(v.step);
    sb.delete();
    acc = 0;
    k   = 0;
    if (v.limit != 8'd0) begin
      do begin
        k++;
        acc += st;
        if (acc > int'(v.limit)) acc = int'(v.limit);
        e.val = 8'(acc);
        e.at  = k * d + ((v.plen > 0 && acc > v.pause_at) ? v.plen : 0);
        sb.push_back(e);
      end while (acc != int'(v.limit));
    end
    @(negedge clk_in);
    cmd_valid = 1'b1; cmd_limit = v.limit; cmd_step = v.step;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    exp_cnt   = 8'd0;
    for (int n = 0; n <= v.done_cyc + 2; n++) begin
      if (sb.size() > 0 && sb[0].at == n) begin
        e = sb.pop_front();
        exp_cnt = e.val;
      end
      check("count", count, exp_cnt);
      check("done", done, n == v.done_cyc);
      check("busy", busy, n < v.done_cyc);
      check("cmd_ready", cmd_ready, n > v.done_cyc);
      pause = (v.plen > 0 && n >= v.pause_at && n < v.pause_at + v.plen) ? 1'b1 : 1'b0;
      @(negedge clk_in);
    end
    pause = 1'b0;
    check("sb_drained", sb.size(), 0);
    check("final_count", count, v.final_cnt);
  endtask

  // Pause at count 9, abort while paused; commands offered while busy must be ignored.
  task automatic abort_seq();
    sel = 1'b0;
    @(negedge clk_in);
    cmd_valid = 1'b1; cmd_limit = 8'd50; cmd_step = 4'd1;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    for (int n = 0; n <= 14; n++) begin
      check("abort_count", count, (n < 9) ? n : 9);
      check("abort_pulse", aborted, n == 12);
      check("abort_no_done", done, 0);
      check("abort_busy", busy, n < 12);
      check("abort_ready", cmd_ready, n >= 12);
      cmd_valid = (n >= 4 && n <= 10) ? 1'b1 : 1'b0;
      cmd_limit = 8'd3;
      pause     = (n >= 9 && n <= 12) ? 1'b1 : 1'b0;
      abort     = (n == 11) ? 1'b1 : 1'b0;
      @(negedge clk_in);
    end
    cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  // Reset at count 12 discards the run without any pulse.
  task automatic reset_seq();
    sel = 1'b0;
    @(negedge clk_in);
    cmd_valid = 1'b1; cmd_limit = 8'd40; cmd_step = 4'd1;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      check("rst_count", count, (n <= 12) ? n : 0);
      check("rst_busy", busy, n <= 12);
      check("rst_ready", cmd_ready, n > 12);
      check("rst_no_done", done, 0);
      check("rst_no_abort", aborted, 0);
      rst = (n == 12) ? 1'b1 : 1'b0;
      @(negedge clk_in);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
    cmd_limit = 8'd0; cmd_step = 4'd0; sel = 1'b0;

    vecs[0] = '{1'b0, 8'd5,   4'd1,  0, 0, 8'd5,   5};
    vecs[1] = '{1'b1, 8'd10,  4'd4,  0, 0, 8'd10,  6};
    vecs[2] = '{1'b0, 8'd0,   4'd7,  0, 0, 8'd0,   0};
    vecs[3] = '{1'b0, 8'd20,  4'd1,  7, 3, 8'd20,  23};
    vecs[4] = '{1'b0, 8'd255, 4'd15, 0, 0, 8'd255, 17};
    vecs[5] = '{1'b1, 8'd3,   4'd0,  0, 0, 8'd3,   6};
    vecs[6] = '{1'b0, 8'd7,   4'd3,  0, 0, 8'd7,   3};
    vecs[7] = '{1'b1, 8'd255, 4'd15, 0, 0, 8'd255, 34};

    do_reset();
    check("rst_count_d1", cnt1, 0);
    check("rst_ready_d1", rdy1, 1);
    check("rst_busy_d1", busy1, 0);
    check("rst_done_d1", done1, 0);
    check("rst_abort_d1", ab1, 0);
    check("rst_count_d2", cnt2, 0);
    check("rst_ready_d2", rdy2, 1);
    check("rst_busy_d2", busy2, 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_vec(vecs[i]);
    end

    do_reset();
    abort_seq();

    do_reset();
    reset_seq();
    run_vec('{1'b0, 8'd3, 4'd0, 0, 0, 8'd3, 3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
